// File: rtl/mem_if_pkg.sv
// ============================================================================
// mem_if_pkg
// Shared types for the banked-memory initiator.
//   line_t    : one 16-byte memory line (128 bits)
//   mstate_e  : burst master FSM states
//   RDWR_*    : encoding of the read/write select on request and interface
// ============================================================================
package mem_if_pkg;

    typedef logic [7:0][15:0] line_t;

    typedef enum logic [1:0] {
        IDLE,
        RD,
        WR,
        DRAIN
    } mstate_e;

    localparam logic RDWR_READ  = 1'b0;
    localparam logic RDWR_WRITE = 1'b1;

endpackage

// File: rtl/line_fifo.sv
// ============================================================================
// line_fifo
// Small synchronous FIFO of memory lines, used as the read-return buffer.
// Ports:
//   clk, rst      clock, asynchronous active-high reset (empties the FIFO)
//   push, wdata   write one line (caller guarantees not full)
//   pop           remove head line (caller guarantees not empty)
//   rdata         head line, forced to 0 while empty
//   count         number of stored lines (0..DEPTH)
//   empty         count == 0
// ============================================================================
module line_fifo
    import mem_if_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  line_t         wdata,
    input  logic          pop,
    output line_t         rdata,
    output logic [CW-1:0] count,
    output logic          empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    line_t         mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    assign empty = (count == '0);
    assign rdata = empty ? '0 : mem[rd_ptr];

    // NOTE: sequential state is assigned with <= so every flop samples the
    // pre-edge values of its inputs, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: the storage array is deliberately not reset; pointers and count
    // define validity, and leaving it out of reset keeps it a plain RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wdata;
        end
    end

endmodule

// File: rtl/mem_burst_master.sv
// ============================================================================
// mem_burst_master
// Turns one host burst request into one line access per cycle on the banked
// memory interface. Reads return through a credit-limited FIFO on a
// valid/ready stream; writes pass straight from the wdata stream to the banks.
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   req_valid/ready/rdwr/addr/len/control   burst request (ready only in IDLE)
//   wdata_valid/ready, wdata     write line stream
//   rdata_valid/ready, rdata     read line stream
//   done                         one-cycle pulse when a burst completes
//   interface_en/rdwr/control/addr, din     memory access outputs
//   bank_dout                    read data, RD_LATENCY cycles after a read
// Optional build macro MEM_MASTER_PERF_EN adds perf_stall_cnt[31:0]: cycles
// spent in RD/WR without issuing, cleared on reset and on request accept.
// ============================================================================
module mem_burst_master
    import mem_if_pkg::*;
#(
    parameter int RD_LATENCY = 1,
    parameter int FIFO_DEPTH = 4,
    parameter int LEN_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_rdwr,
    input  logic [31:0]      req_addr,
    input  logic [LEN_W-1:0] req_len,
    input  logic [4:0]       req_control,
    input  logic             wdata_valid,
    output logic             wdata_ready,
    input  line_t            wdata,
    output logic             rdata_valid,
    input  logic             rdata_ready,
    output line_t            rdata,
    output logic             done,
    output logic             interface_en,
    output logic             interface_rdwr,
    output logic [4:0]       interface_control,
    output logic [31:0]      interface_addr,
    output line_t            din,
    input  line_t            bank_dout
`ifdef MEM_MASTER_PERF_EN
    ,
    output logic [31:0]      perf_stall_cnt
`endif
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int OW = $clog2(RD_LATENCY + 1);

    mstate_e               state;
    logic                  ready_q;
    logic                  done_q;
    logic [LEN_W-1:0]      remaining_q;
    logic [31:0]           next_addr_q;
    logic [31:0]           last_addr_q;
    logic [4:0]            ctrl_q;
    line_t                 din_q;
    logic [RD_LATENCY-1:0] vpipe;
    logic [OW-1:0]         outstanding_q;

    logic [CW-1:0] fifo_count;
    logic          fifo_empty;
    logic          credit_ok;
    logic          issue_rd;
    logic          issue_wr;
    logic          issue;
    logic          push;
    logic          pop;
    logic          drain_done;

    // A read may issue only if its data is guaranteed a FIFO slot: lines in
    // flight plus lines already buffered must stay below the FIFO depth.
    assign credit_ok  = (int'(outstanding_q) + int'(fifo_count)) < FIFO_DEPTH;
    assign issue_rd   = (state == RD) && credit_ok;
    assign issue_wr   = (state == WR) && wdata_valid;
    assign issue      = issue_rd || issue_wr;
    assign push       = vpipe[RD_LATENCY-1];
    assign pop        = rdata_valid && rdata_ready;
    assign drain_done = (outstanding_q == '0) &&
                        ((fifo_count == '0) || ((fifo_count == CW'(1)) && pop));

    // Write path is a zero-latency pass-through; address and data hold their
    // last driven values on idle cycles.
    assign interface_en      = issue;
    assign interface_rdwr    = issue_wr;
    assign interface_addr    = issue ? next_addr_q : last_addr_q;
    assign din               = issue_wr ? wdata : din_q;
    assign interface_control = ctrl_q;
    assign wdata_ready       = (state == WR);
    assign rdata_valid       = !fifo_empty;
    assign req_ready         = ready_q;
    assign done              = done_q;

    line_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_rd_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (push),
        .wdata(bank_dout),
        .pop  (pop),
        .rdata(rdata),
        .count(fifo_count),
        .empty(fifo_empty)
    );

    // Burst FSM. ready_q is registered and held low in the done cycle, so
    // done and req_ready are never high together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            ready_q     <= 1'b0;
            done_q      <= 1'b0;
            remaining_q <= '0;
            next_addr_q <= '0;
            ctrl_q      <= '0;
        end else begin
            done_q  <= 1'b0;
            ready_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid && ready_q) begin
                        next_addr_q <= req_addr;
                        remaining_q <= req_len;
                        ctrl_q      <= req_control;
                        if (req_len == '0) begin
                            done_q <= 1'b1;
                        end else if (req_rdwr == RDWR_WRITE) begin
                            state <= WR;
                        end else begin
                            state <= RD;
                        end
                    end else begin
                        ready_q <= 1'b1;
                    end
                end
                RD: begin
                    if (issue_rd) begin
                        next_addr_q <= next_addr_q + 32'd1;
                        remaining_q <= remaining_q - 1'b1;
                        if (remaining_q == LEN_W'(1)) begin
                            state <= DRAIN;
                        end
                    end
                end
                WR: begin
                    if (issue_wr) begin
                        next_addr_q <= next_addr_q + 32'd1;
                        remaining_q <= remaining_q - 1'b1;
                        if (remaining_q == LEN_W'(1)) begin
                            state  <= IDLE;
                            done_q <= 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (drain_done) begin
                        state  <= IDLE;
                        done_q <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Read-valid pipe tracks each issued read until its data is on bank_dout;
    // outstanding_q is the number of ones in that pipe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vpipe         <= '0;
            outstanding_q <= '0;
            last_addr_q   <= '0;
            din_q         <= '0;
        end else begin
            vpipe[0] <= issue_rd;
            for (int k = 1; k < RD_LATENCY; k++) begin
                vpipe[k] <= vpipe[k-1];
            end
            case ({issue_rd, push})
                2'b10:   outstanding_q <= outstanding_q + 1'b1;
                2'b01:   outstanding_q <= outstanding_q - 1'b1;
                default: outstanding_q <= outstanding_q;
            endcase
            if (issue) begin
                last_addr_q <= next_addr_q;
            end
            if (issue_wr) begin
                din_q <= wdata;
            end
        end
    end

`ifdef MEM_MASTER_PERF_EN
    logic [31:0] perf_q;

    assign perf_stall_cnt = perf_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_q <= '0;
        end else if (req_valid && ready_q) begin
            perf_q <= '0;
        end else if (((state == RD) || (state == WR)) && !issue &&
                     (perf_q != 32'hFFFF_FFFF)) begin
            perf_q <= perf_q + 32'd1;
        end
    end
`endif

endmodule
